shr_issue_stage: RTL and testbench
==================================

Name: shr_issue_stage

Overview:
- Sequential operand-issue stage that sits directly upstream of the combinational SHR datapath component and feeds it.
- Buffers (a, sh_amt) operand pairs in a DEPTH-entry FIFO and presents the FIFO head to an instantiated SHR.
- Captures the SHR result in an output register with a valid/ready handshake.
- Converts the unregistered shifter into a pipelined, back-pressurable stage usable between clocked datapath blocks.

Parameters:
- DATAWIDTH, 8, width of operand a, shift amount sh_amt and result d.
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- CNTW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous active-low reset; 0 resets all state immediately.
- in_valid  input  1  upstream offers an operand pair.
- in_ready  output  1  stage can accept; equals (count != DEPTH).
- in_a  input  DATAWIDTH  value to shift.
- in_sh_amt  input  DATAWIDTH  logical right-shift amount.
- out_valid  output  1  out_d holds an unconsumed result.
- out_ready  input  1  downstream accepts out_d.
- out_d  output  DATAWIDTH  registered result.
- count  output  CNTW  FIFO occupancy, 0..DEPTH; excludes the output register.

Behaviour:
- Reset (Rst=0, asynchronous):
  - Write/read pointers, count, out_valid and out_d all go to 0.
  - in_ready is therefore 1 while in reset.
- push = in_valid & in_ready.
  - On push, {in_a, in_sh_amt} is written at wr_ptr; wr_ptr increments modulo DEPTH.
- SHR instance:
  - Inputs are the FIFO head entry.
  - Result is a logical right shift, zero-filled.
  - sh_amt >= DATAWIDTH yields 0.
  - No width growth and no sign extension.
- load = (count != 0) & (~out_valid | out_ready).
  - On load: out_d <= SHR result of head, out_valid <= 1, pop (rd_ptr increments modulo DEPTH).
- Output register:
  - If out_valid & out_ready and no load, out_valid <= 0; out_d holds its last value.
  - out_d is stable while out_valid=1 and out_ready=0.
- Count update: count <= count + push - pop. Simultaneous push and pop leave count unchanged, including at count=DEPTH-1 and count=1.
- Latency:
  - A pair accepted at edge k appears with out_valid=1 after edge k+1, provided the FIFO was empty and the output was free or being consumed.
  - No combinational bypass from in_* to out_*.
- Throughput: one result per cycle with out_ready held at 1.
- in_ready depends only on registered count, never combinationally on out_ready. Full means in_ready=0, even when a pop occurs in the same cycle.
- Empty FIFO: no load. The head entry and SHR output are don't-care.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally.
- Ordering: results leave strictly in acceptance order. No drop, duplication or reordering.
- Reset mid-operation: all buffered and in-flight data is discarded. The first post-reset push behaves as from an empty stage.
- No overflow or underflow is possible by construction. A bench assertion flags any write when count==DEPTH.

Decomposition:
- Shared header (shr_defs.vh) holds:
  - DATAWIDTH default.
  - DEPTH default.
  - Entry-packing macro ENTRY_W = 2*DATAWIDTH.
- Sub-module: reuse the existing SHR component as the datapath instance; do not re-implement the shift.
- The FIFO storage and pointers stay inline; no separate FIFO module.

Test Plan:
- Reset, then push (20,1), (20,3), (40,4) back-to-back with out_ready=1 -> out_d sequence 10, 2, 2 on consecutive cycles; first out_valid one cycle after first accept.
- Push (255,7), (255,8), (129,0) -> 1, 0, 129. The sh_amt >= DATAWIDTH case must give 0.
- Hold out_ready=0, push (8'hF0, k) for k=0..5:
  - 5 pairs accepted (1 in the output register, 4 in the FIFO); count=4 and in_ready=0 on the 6th.
  - Then release out_ready -> 240, 120, 60, 30, 15 in order, followed by the 6th pair's result 7 once it is accepted.
- At count=3, assert push and pop in the same cycle -> count stays 3. Repeat with pointers crossing the wrap at entry 3->0; ordering is preserved.
- With out_valid=1, toggle out_ready 0/1 each cycle -> out_d holds while stalled and no result is skipped or repeated. Compare against a reference queue.
- Assert Rst=0 asynchronously mid-burst with count=2 -> out_valid, count and out_d are 0 immediately. After release, push (40,4) -> single result 2.

Source files
------------

// File: rtl/shr_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shr_issue_stage_pkg
//  Purpose  : Shared defaults and FIFO-entry packing helper for the SHR
//             operand-issue stage.
//  Contents : DEF_DATAWIDTH - default operand/result width
//             DEF_DEPTH     - default operand FIFO depth
//             entry_w()     - width of one packed {a, sh_amt} FIFO entry
//  Revision : 1.0 - initial release
// ============================================================================
package shr_issue_stage_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_DEPTH     = 4;

    // One FIFO entry carries the value to shift and its shift amount side by
    // side, so it is twice the datapath width.
    function automatic int entry_w(input int dw);
        return 2 * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shr_issue_stage_shr.sv
`default_nettype none
// ============================================================================
//  Module   : shr_issue_stage_shr
//  Purpose  : Combinational logical right shifter (SHR datapath component).
//             Zero-filled, no sign extension, no width growth; any shift
//             amount >= DATAWIDTH produces zero.
//  Ports    : a_i      [DATAWIDTH] value to shift
//             sh_amt_i [DATAWIDTH] shift amount
//             d_o      [DATAWIDTH] shifted result
//  Revision : 1.0 - initial release
// ============================================================================
module shr_issue_stage_shr #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] sh_amt_i,
    output logic [DATAWIDTH-1:0] d_o
);

    // The >> operator is logical and yields zero once the amount reaches the
    // operand width, which is exactly the required out-of-range behaviour.
    assign d_o = a_i >> sh_amt_i;

endmodule
`default_nettype wire

// File: rtl/shr_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shr_issue_stage
//  Purpose  : Pipelined, back-pressurable issue stage in front of the SHR
//             shifter. Operand pairs are buffered in a DEPTH-entry FIFO; the
//             FIFO head is shifted and captured in a valid/ready output
//             register.
//  Ports    : Clk        rising-edge clock
//             Rst        asynchronous active-low reset
//             in_valid   upstream offers {in_a, in_sh_amt}
//             in_ready   FIFO not full (registered count only)
//             in_a       value to shift
//             in_sh_amt  logical right-shift amount
//             out_valid  out_d holds an unconsumed result
//             out_ready  downstream accepts out_d
//             out_d      registered shift result
//             count      FIFO occupancy 0..DEPTH (output register excluded)
//  Revision : 1.0 - initial release
// ============================================================================
module shr_issue_stage
    import shr_issue_stage_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNTW      = $clog2(DEPTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_sh_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_d,
    output logic [CNTW-1:0]      count
);

    localparam int              PTRW    = $clog2(DEPTH);
    localparam int              ENTRY_W = entry_w(DATAWIDTH);
    localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] out_d_q, out_d_d;

    logic                 push;
    logic                 load;
    logic [ENTRY_W-1:0]   head;
    logic [DATAWIDTH-1:0] shr_d;

    // Readiness comes from the registered count alone, so a full FIFO refuses
    // input even in a cycle where it also pops.
    assign in_ready = (count_q != FULL);
    assign push     = in_valid & in_ready;
    assign load     = (count_q != '0) & (~out_valid_q | out_ready);

    assign head = mem_q[rd_ptr_q];

    shr_issue_stage_shr #(
        .DATAWIDTH (DATAWIDTH)
    ) u_shr (
        .a_i      (head[ENTRY_W-1 -: DATAWIDTH]),
        .sh_amt_i (head[DATAWIDTH-1:0]),
        .d_o      (shr_d)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d_d     = out_d_q;

        // Pointers are PTRW bits wide and DEPTH is a power of two, so the
        // increment wraps on its own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (load) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_d_d     = shr_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case ({push, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
        end
    end

    // Storage is not reset: an entry is only ever read after it was written,
    // and reset clears the pointers and count that qualify it.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_sh_amt};
        end
    end

    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shr_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shr_issue_stage
//  Purpose  : Directed self-checking bench for shr_issue_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shr_issue_stage;

    logic       Clk;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_sh_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_d;
    logic [2:0] count;

    int n_assert;
    int n_fail;

    logic [7:0] exp_q[$];

    shr_issue_stage #(
        .DATAWIDTH (8),
        .DEPTH     (4),
        .CNTW      (3)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_sh_amt (in_sh_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .count     (count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] ref_shr(input logic [7:0] a, input logic [7:0] s);
        if (s >= 8'd8) return 8'd0;
        return a >> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe the pre-edge handshake (scoreboard, full guard,
    // stall capture), take the edge, then settle 1 time unit after it.
    task automatic cyc();
        logic       stall;
        logic [7:0] hold;
        #2;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_result", 32'(out_d), 32'hFFFF_FFFF);
            else                   chk("sb_order", 32'(out_d), 32'(exp_q.pop_front()));
        end
        if (in_valid && count == 3'd4) chk("full_no_write", 32'(in_ready), 32'd0);
        if (in_valid && in_ready) exp_q.push_back(ref_shr(in_a, in_sh_amt));
        stall = out_valid && !out_ready;
        hold  = out_d;
        @(posedge Clk);
        #1;
        if (stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold",  32'(out_d),     32'(hold));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] s);
        in_valid  = v;
        in_a      = a;
        in_sh_amt = s;
    endtask

    initial begin
        int idx;
        logic [7:0] ta [4];
        logic [7:0] ts [4];
        n_assert = 0;
        n_fail   = 0;

        // ---------------- reset ----------------
        Rst = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_d",     32'(out_d),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b1;

        // ---------------- back-to-back pushes, out_ready=1 ----------------
        out_ready = 1'b1;
        drive(1'b1, 8'd20, 8'd1); cyc();
        chk("t1_first_count", 32'(count), 32'd1);
        chk("t1_first_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 8'd20, 8'd3); cyc();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_d0", 32'(out_d), 32'd10);
        drive(1'b1, 8'd40, 8'd4); cyc();
        chk("t1_d1", 32'(out_d), 32'd2);
        drive(1'b0, 8'd0, 8'd0); cyc();
        chk("t1_d2", 32'(out_d), 32'd2);
        chk("t1_d2_valid", 32'(out_valid), 32'd1);
        cyc();
        chk("t1_drained", 32'(out_valid), 32'd0);
        chk("t1_count0", 32'(count), 32'd0);

        // ---------------- edge shift amounts ----------------
        drive(1'b1, 8'd255, 8'd7); cyc();
        drive(1'b1, 8'd255, 8'd8); cyc();
        chk("t2_sh7", 32'(out_d), 32'd1);
        drive(1'b1, 8'd129, 8'd0); cyc();
        chk("t2_sh8_zero", 32'(out_d), 32'd0);
        drive(1'b0, 8'd0, 8'd0); cyc();
        chk("t2_sh0", 32'(out_d), 32'd129);
        cyc();

        // ---------------- fill under back-pressure ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'hF0, 8'(k)); cyc();
        end
        chk("t3_count_full", 32'(count), 32'd4);
        chk("t3_in_ready0",  32'(in_ready), 32'd0);
        chk("t3_head_d",     32'(out_d), 32'd240);
        drive(1'b1, 8'hF0, 8'd5); cyc();
        chk("t3_still_full", 32'(count), 32'd4);
        out_ready = 1'b1; cyc();
        chk("t3_r1", 32'(out_d), 32'd120);
        chk("t3_r1_count", 32'(count), 32'd3);
        chk("t3_r1_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("t3_r2", 32'(out_d), 32'd60);
        chk("t3_r2_count", 32'(count), 32'd3);
        drive(1'b0, 8'd0, 8'd0); cyc();
        chk("t3_r3", 32'(out_d), 32'd30);
        cyc();
        chk("t3_r4", 32'(out_d), 32'd15);
        cyc();
        chk("t3_r5", 32'(out_d), 32'd7);
        chk("t3_r5_count", 32'(count), 32'd0);
        cyc();
        chk("t3_drained", 32'(out_valid), 32'd0);

        // ---------------- push+pop at count=3 across pointer wrap ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'h80, 8'(k)); cyc();
        end
        chk("t4_count3", 32'(count), 32'd3);
        chk("t4_head", 32'(out_d), 32'd128);
        out_ready = 1'b1;
        drive(1'b1, 8'h80, 8'd4); cyc();
        chk("t4_pp_count_a", 32'(count), 32'd3);
        chk("t4_pp_d_a", 32'(out_d), 32'd64);
        drive(1'b1, 8'h80, 8'd5); cyc();
        chk("t4_pp_count_b", 32'(count), 32'd3);
        chk("t4_pp_d_b", 32'(out_d), 32'd32);
        drive(1'b1, 8'h80, 8'd6); cyc();
        chk("t4_pp_count_c", 32'(count), 32'd3);
        chk("t4_pp_d_c", 32'(out_d), 32'd16);
        drive(1'b0, 8'd0, 8'd0); cyc();
        chk("t4_d_8", 32'(out_d), 32'd8);
        cyc();
        chk("t4_d_4", 32'(out_d), 32'd4);
        cyc();
        chk("t4_d_2", 32'(out_d), 32'd2);
        chk("t4_count0", 32'(count), 32'd0);
        cyc();
        chk("t4_drained", 32'(out_valid), 32'd0);

        // ---------------- out_ready toggling, checked by scoreboard ----------------
        ta[0] = 8'd200; ts[0] = 8'd1;
        ta[1] = 8'd77;  ts[1] = 8'd2;
        ta[2] = 8'd9;   ts[2] = 8'd9;
        ta[3] = 8'd63;  ts[3] = 8'd3;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = c[0];
            if (idx < 4) drive(1'b1, ta[idx], ts[idx]);
            else         drive(1'b0, 8'd0, 8'd0);
            if (in_valid && in_ready) idx++;
            cyc();
        end
        chk("t5_all_issued", 32'(idx), 32'd4);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_drained", 32'(out_valid), 32'd0);

        // ---------------- asynchronous reset mid-burst ----------------
        out_ready = 1'b0;
        drive(1'b1, 8'd100, 8'd1); cyc();
        drive(1'b1, 8'd100, 8'd2); cyc();
        drive(1'b1, 8'd100, 8'd3); cyc();
        drive(1'b0, 8'd0, 8'd0);
        chk("t6_pre_count", 32'(count), 32'd2);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2 Rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_d", 32'(out_d), 32'd0);
        exp_q.delete();
        #2 Rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'd40, 8'd4); cyc();
        chk("t6_post_count", 32'(count), 32'd1);
        chk("t6_post_nv", 32'(out_valid), 32'd0);
        drive(1'b0, 8'd0, 8'd0); cyc();
        chk("t6_post_d", 32'(out_d), 32'd2);
        chk("t6_post_valid", 32'(out_valid), 32'd1);
        cyc();
        chk("t6_single", 32'(out_valid), 32'd0);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
